// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the digit-serial BCD add/subtract unit.
package bcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CALC,
        COMP,
        DONE
    } state_e;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_SIX  = 4'd6;

    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_NINE - digit;
    endfunction

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= BCD_NINE;
    endfunction

endpackage

// File: rtl/bcd_alu_seq_if.sv
// Request/response bundle between the operand registers and the BCD ALU.
interface bcd_alu_seq_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         negative;
    logic         valid;

    modport master (
        output start, a, b, op,
        input  busy, done, result, carry, negative, valid
    );

    modport slave (
        input  start, a, b, op,
        output busy, done, result, carry, negative, valid
    );

endinterface

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with decimal correction; shared by add and complement passes.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] sum;

    always_comb begin
        sum  = {1'b0, x} + {1'b0, y} + {4'b0, cin};
        cout = sum > {1'b0, BCD_NINE};
        s    = cout ? (sum[3:0] + BCD_SIX) : sum[3:0];
    end

endmodule

// File: rtl/bcd_alu_seq.sv
// Digit-serial BCD add/subtract, LSD first, signed-magnitude result.
module bcd_alu_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input logic          clk,
    input logic          rst,
    bcd_alu_seq_if.slave bus
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  result_q, result_d;
    logic          op_q, op_d;
    logic          cin_q, cin_d;
    logic          carry_q, carry_d;
    logic          negative_q, negative_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [3:0] x, y, s;
    logic       cout;
    logic       operands_ok;

    bcd_digit_adder u_add (
        .x    (x),
        .y    (y),
        .cin  (cin_q),
        .s    (s),
        .cout (cout)
    );

    always_comb begin
        operands_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(a_q[4*i +: 4]) || !is_bcd(b_q[4*i +: 4])) operands_ok = 1'b0;
        end
    end

    // COMP re-feeds the raw difference; CALC feeds A and B (or B's nines' complement)
    always_comb begin
        x = a_q[4*int'(idx_q) +: 4];
        y = op_q ? nines_comp(b_q[4*int'(idx_q) +: 4]) : b_q[4*int'(idx_q) +: 4];
        if (state_q == COMP) begin
            x = nines_comp(result_q[4*int'(idx_q) +: 4]);
            y = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cin_d      = cin_q;
        idx_d      = idx_q;
        result_d   = result_q;
        carry_d    = carry_q;
        negative_d = negative_q;
        valid_d    = valid_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!operands_ok) begin
                    result_d   = '0;
                    carry_d    = 1'b0;
                    negative_d = 1'b0;
                    valid_d    = 1'b0;
                    state_d    = DONE;
                end else begin
                    idx_d   = '0;
                    cin_d   = op_q;
                    state_d = CALC;
                end
            end
            CALC: begin
                result_d[4*int'(idx_q) +: 4] = s;
                cin_d = cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    if (op_q && !cout) begin
                        idx_d   = '0;
                        cin_d   = 1'b1;
                        state_d = COMP;
                    end else begin
                        carry_d    = !op_q && cout;
                        negative_d = 1'b0;
                        valid_d    = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            COMP: begin
                result_d[4*int'(idx_q) +: 4] = s;
                cin_d = cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    carry_d    = 1'b0;
                    negative_d = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            cin_q      <= 1'b0;
            idx_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            negative_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            cin_q      <= cin_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            negative_q <= negative_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.busy     = (state_q == CHECK) || (state_q == CALC) || (state_q == COMP);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.negative = negative_q;
    assign bus.valid    = valid_q;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Scoreboard bench for bcd_alu_seq at DIGITS = 4, 1 and 8.
module tb_bcd_alu_seq;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        n;
        logic        v;
        int          lat;
        int          sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    exp_t q4[$], q1[$], q8[$];
    exp_t e4, e1, e8;

    bcd_alu_seq_if #(.DIGITS(4)) b4 ();
    bcd_alu_seq_if #(.DIGITS(1)) b1 ();
    bcd_alu_seq_if #(.DIGITS(8)) b8 ();

    bcd_alu_seq #(.DIGITS(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
    bcd_alu_seq #(.DIGITS(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    bcd_alu_seq #(.DIGITS(8)) u8 (.clk(clk), .rst(rst), .bus(b8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp(input string t, input logic [31:0] r, input logic c, input logic n,
                       input logic v, input logic busy, input exp_t e);
        check({t, "_res"}, r, e.res);
        check({t, "_carry"}, 32'(c), 32'(e.c));
        check({t, "_neg"}, 32'(n), 32'(e.n));
        check({t, "_valid"}, 32'(v), 32'(e.v));
        check({t, "_busy_at_done"}, 32'(busy), 32'd0);
        check({t, "_latency"}, 32'(cyc - e.sc + 1), 32'(e.lat));
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic c, input logic n,
                                input logic v, input int lat);
        exp_t e;
        e.res = r; e.c = c; e.n = n; e.v = v; e.lat = lat; e.sc = 0;
        return e;
    endfunction

    function automatic int bcd2int(input logic [15:0] x);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t model4(input logic [15:0] a, input logic [15:0] b, input logic op);
        int av = bcd2int(a);
        int bv = bcd2int(b);
        if (!op) return mk(32'(int2bcd((av + bv) % 10000)), (av + bv) > 9999, 1'b0, 1'b1, 6);
        if (av >= bv) return mk(32'(int2bcd(av - bv)), 1'b0, 1'b0, 1'b1, 6);
        return mk(32'(int2bcd(bv - av)), 1'b0, 1'b1, 1'b1, 10);
    endfunction

    always @(negedge clk) if (!rst && b4.done) begin
        if (q4.size() == 0) check("d4_unexpected_done", 32'd1, 32'd0);
        else begin
            e4 = q4.pop_front();
            cmp("d4", 32'(b4.result), b4.carry, b4.negative, b4.valid, b4.busy, e4);
        end
    end

    always @(negedge clk) if (!rst && b1.done) begin
        if (q1.size() == 0) check("d1_unexpected_done", 32'd1, 32'd0);
        else begin
            e1 = q1.pop_front();
            cmp("d1", 32'(b1.result), b1.carry, b1.negative, b1.valid, b1.busy, e1);
        end
    end

    always @(negedge clk) if (!rst && b8.done) begin
        if (q8.size() == 0) check("d8_unexpected_done", 32'd1, 32'd0);
        else begin
            e8 = q8.pop_front();
            cmp("d8", b8.result, b8.carry, b8.negative, b8.valid, b8.busy, e8);
        end
    end

    task automatic launch(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input exp_t e, input bit push);
        exp_t x = e;
        @(negedge clk);
        x.sc = cyc + 1;
        case (sel)
            1: begin
                b1.start = 1'b1; b1.a = a[3:0]; b1.b = b[3:0]; b1.op = op;
                if (push) q1.push_back(x);
            end
            8: begin
                b8.start = 1'b1; b8.a = a; b8.b = b; b8.op = op;
                if (push) q8.push_back(x);
            end
            default: begin
                b4.start = 1'b1; b4.a = a[15:0]; b4.b = b[15:0]; b4.op = op;
                if (push) q4.push_back(x);
            end
        endcase
        @(negedge clk);
        b1.start = 1'b0; b4.start = 1'b0; b8.start = 1'b0;
        // scramble the bus: the captured copy must be what gets computed
        b1.a = '1; b4.a = '1; b8.a = '1;
        b1.b = '1; b4.b = '1; b8.b = '1;
        case (sel)
            1: check("d1_busy", 32'(b1.busy), 32'd1);
            8: check("d8_busy", 32'(b8.busy), 32'd1);
            default: check("d4_busy", 32'(b4.busy), 32'd1);
        endcase
    endtask

    task automatic drain();
        int k = 0;
        while ((q4.size() + q1.size() + q8.size()) != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            check("drain_timeout", 32'd1, 32'd0);
            q4.delete(); q1.delete(); q8.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   k;
        logic [15:0] ra, rb;
        logic        rop;
        b1.start = 0; b1.a = '0; b1.b = '0; b1.op = 0;
        b4.start = 0; b4.a = '0; b4.b = '0; b4.op = 0;
        b8.start = 0; b8.a = '0; b8.b = '0; b8.op = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(b4.busy), 0);
        check("rst_done", 32'(b4.done), 0);
        check("rst_result", 32'(b4.result), 0);
        check("rst_flags", 32'({b4.carry, b4.negative, b4.valid}), 0);
        rst = 1'b0;

        launch(4, 32'h1234, 32'h5678, 0, mk(32'h6912, 0, 0, 1, 6), 1); drain();
        launch(4, 32'h9999, 32'h0001, 0, mk(32'h0000, 1, 0, 1, 6), 1); drain();
        launch(4, 32'h5000, 32'h5000, 0, mk(32'h0000, 1, 0, 1, 6), 1); drain();
        launch(4, 32'h0500, 32'h0123, 1, mk(32'h0377, 0, 0, 1, 6), 1); drain();
        launch(4, 32'h0123, 32'h0500, 1, mk(32'h0377, 0, 1, 1, 10), 1); drain();
        launch(4, 32'h0042, 32'h0042, 1, mk(32'h0000, 0, 0, 1, 6), 1); drain();
        launch(4, 32'h0000, 32'h0000, 1, mk(32'h0000, 0, 0, 1, 6), 1); drain();
        launch(4, 32'h12A4, 32'h0001, 0, mk(32'h0000, 0, 0, 0, 2), 1); drain();
        launch(4, 32'h8765, 32'h1111, 0, mk(32'h9876, 0, 0, 1, 6), 1); drain();
        launch(4, 32'h0100, 32'h00F0, 1, mk(32'h0000, 0, 0, 0, 2), 1); drain();

        // a second start while busy must not disturb the running op
        launch(4, 32'h1111, 32'h2222, 0, mk(32'h3333, 0, 0, 1, 6), 1);
        @(negedge clk);
        b4.start = 1'b1; b4.a = 16'h4444; b4.b = 16'h4444; b4.op = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
        drain();

        // start held through the DONE cycle launches the next op
        @(negedge clk);
        b4.start = 1'b1; b4.a = 16'h0250; b4.b = 16'h0100; b4.op = 1'b0;
        e = mk(32'h0350, 0, 0, 1, 6); e.sc = cyc + 1; q4.push_back(e);
        @(negedge clk);
        b4.a = 16'h0001; b4.b = 16'h0009; b4.op = 1'b1;
        k = 0;
        while (!b4.done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("b2b_first_done", 32'(b4.done), 1);
        e = mk(32'h0008, 0, 1, 1, 10); e.sc = cyc + 1; q4.push_back(e);
        @(negedge clk);
        b4.start = 1'b0;
        drain();

        // reset in the middle of CALC aborts without a done pulse
        launch(4, 32'h0123, 32'h0500, 1, mk(0, 0, 0, 0, 0), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(b4.busy), 0);
        check("midrst_done", 32'(b4.done), 0);
        check("midrst_result", 32'(b4.result), 0);
        check("midrst_flags", 32'({b4.carry, b4.negative, b4.valid}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_idle", 32'(b4.busy), 0);

        for (int i = 0; i < 12; i++) begin
            ra  = int2bcd(int'($urandom_range(0, 9999)));
            rb  = int2bcd(int'($urandom_range(0, 9999)));
            rop = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 16'h9999; rb = 16'h9999; rop = 1'b0; end
            if (i == 1) begin ra = 16'h0000; rb = 16'h9999; rop = 1'b1; end
            launch(4, 32'(ra), 32'(rb), rop, model4(ra, rb, rop), 1);
            drain();
        end

        launch(1, 32'h7, 32'h5, 0, mk(32'h2, 1, 0, 1, 3), 1); drain();
        launch(1, 32'h3, 32'h8, 1, mk(32'h5, 0, 1, 1, 4), 1); drain();
        launch(8, 32'h00000001, 32'h99999999, 1, mk(32'h99999998, 0, 1, 1, 18), 1); drain();
        launch(8, 32'h99999999, 32'h99999999, 0, mk(32'h99999998, 1, 0, 1, 10), 1); drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
